// File: rtl/instruction_fetch_unit.sv
// ----------------------------------------------------------------------------
// instruction_fetch_unit
//
// Purpose:
//   Sequences a 256-word synchronous instruction ROM (one-cycle read latency)
//   for the core. Holds the program counter, drives the ROM address, tracks the
//   single outstanding ROM read, and buffers returned words in a 3-entry queue
//   that feeds the decode stage over a valid/ready handshake. Handles
//   redirects from branch/jump resolution plus start/halt control.
//
// Parameters:
//   BOOT_ADDR        PC value loaded on reset.
//   DEPTH            instruction queue entries; the design assumes exactly 3.
//
// Ports:
//   clock            single clock, all registers update on the rising edge
//   reset            synchronous, active-high
//   start            pulse: in IDLE or HALT, begin fetching from the current PC
//   halt             pulse: in RUN, stop issuing new fetches
//   rom_address      ROM address, driven directly from the PC register
//   rom_instruction  ROM data, valid one cycle after the address is sampled
//   redirect_valid   branch/jump taken this cycle
//   redirect_target  new PC for the redirect
//   inst_valid       queue head is valid
//   inst_ready       decode accepts the head this cycle
//   inst_data        head instruction word
//   inst_pc          address of the head instruction
//   busy             state is RUN or a fetch is still in flight
// ----------------------------------------------------------------------------
module instruction_fetch_unit #(
   parameter logic [7:0]  BOOT_ADDR = 8'd0,
   parameter int unsigned DEPTH     = 3
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       start,
   input  logic       halt,
   output logic [7:0] rom_address,
   input  logic [8:0] rom_instruction,
   input  logic       redirect_valid,
   input  logic [7:0] redirect_target,
   output logic       inst_valid,
   input  logic       inst_ready,
   output logic [8:0] inst_data,
   output logic [7:0] inst_pc,
   output logic       busy
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_HALT = 2'd2
   } state_t;

   // ------------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------------
   state_t     state;
   logic [7:0] pc;          // next address to fetch
   logic [7:0] tag;         // address of the word currently in flight
   logic       inflight;    // a ROM read was issued last cycle
   logic [1:0] count;       // queue occupancy, 0..3
   logic [1:0] head;        // read pointer
   logic [1:0] tail;        // write pointer

   logic [8:0] queue_data [DEPTH];
   logic [7:0] queue_pc   [DEPTH];

   logic       do_issue;
   logic       do_enq;
   logic       do_deq;

   // Pointer advance for a 3-entry circular buffer held in 2-bit pointers.
   function automatic logic [1:0] ptr_next(input logic [1:0] ptr);
      return (ptr == 2'(DEPTH - 1)) ? 2'd0 : ptr + 2'd1;
   endfunction

   // ------------------------------------------------------------------------
   // Control decisions
   // ------------------------------------------------------------------------
   // Issue credit uses only registered occupancy and in-flight state, so a
   // same-cycle dequeue never frees a slot early and inst_ready has no path
   // into the ROM address. A redirect owns the PC this cycle, so no issue is
   // booked against the old stream.
   assign do_issue = (state == S_RUN) && !redirect_valid &&
                     (({1'b0, count} + {2'b00, inflight}) < 3'(DEPTH));

   // The returning word is dropped when a redirect lands on the same edge.
   assign do_enq   = inflight && !redirect_valid;
   assign do_deq   = inst_valid && inst_ready;

   // ------------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------------
   assign rom_address = pc;
   assign inst_valid  = (count != 2'd0);
   // Gate the head with valid so an empty queue presents zeros rather than
   // whatever the unreset storage happens to hold.
   assign inst_data   = inst_valid ? queue_data[head] : 9'd0;
   assign inst_pc     = inst_valid ? queue_pc[head]   : 8'd0;

   // ------------------------------------------------------------------------
   // Control FSM, PC, in-flight tracking and queue pointers
   // ------------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking assignments only, so every
   // register sees the pre-edge values of its neighbours regardless of the
   // order of the statements below.
   always_ff @(posedge clock) begin
      if (reset) begin
         state    <= S_IDLE;
         busy     <= 1'b0;
         pc       <= BOOT_ADDR;
         tag      <= 8'd0;
         inflight <= 1'b0;
         count    <= 2'd0;
         head     <= 2'd0;
         tail     <= 2'd0;
      end else begin
         // busy is registered: it reflects next-cycle state and in-flight,
         // where next in-flight is exactly this cycle's issue decision.
         case (state)
            S_RUN: begin
               if (halt) begin
                  state <= S_HALT;
                  busy  <= do_issue;
               end else begin
                  busy  <= 1'b1;
               end
            end
            S_IDLE, S_HALT: begin
               if (start) begin
                  state <= S_RUN;
                  busy  <= 1'b1;
               end else begin
                  busy  <= do_issue;
               end
            end
            default: begin
               state <= S_IDLE;
               busy  <= 1'b0;
            end
         endcase

         // Redirect wins over sequential advance; the 8-bit PC wraps 255 -> 0.
         if (redirect_valid) begin
            pc <= redirect_target;
         end else if (do_issue) begin
            pc <= pc + 8'd1;
         end

         if (do_issue) begin
            tag <= pc;
         end

         // Cleared on return unless a new read goes out in the same cycle;
         // a redirect suppresses do_issue and so also kills the old read.
         inflight <= do_issue;

         if (redirect_valid) begin
            count <= 2'd0;
            head  <= 2'd0;
            tail  <= 2'd0;
         end else begin
            if (do_enq) begin
               tail <= ptr_next(tail);
            end
            if (do_deq) begin
               head <= ptr_next(head);
            end
            case ({do_enq, do_deq})
               2'b10:   count <= count + 2'd1;
               2'b01:   count <= count - 2'd1;
               default: count <= count;
            endcase
         end
      end
   end

   // ------------------------------------------------------------------------
   // Queue storage
   // ------------------------------------------------------------------------
   // NOTE: the storage array is deliberately left out of reset; occupancy and
   // pointers define which entries are meaningful, and the outputs are gated
   // by inst_valid, so clearing the array would only cost reset fan-out.
   always_ff @(posedge clock) begin
      if (do_enq) begin
         queue_data[tail] <= rom_instruction;
         queue_pc[tail]   <= tag;
      end
   end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// ----------------------------------------------------------------------------
// tb_instruction_fetch_unit
//
// Purpose:
//   Directed testbench for instruction_fetch_unit. Two instances: one with the
//   default boot address, one with BOOT_ADDR = 8'hFE to exercise PC wrap.
//   Each has a one-cycle-latency ROM model with ROM[i] = i + 9'h100.
//   Inputs change 1 time unit after a rising edge; outputs are observed there.
//   Cycle k below is the interval ending at edge k, where start is sampled at
//   edge 0.
// ----------------------------------------------------------------------------
module tb_instruction_fetch_unit;

   logic       clock = 1'b0;
   logic       reset;
   logic       start;
   logic       halt;
   logic       redirect_valid;
   logic [7:0] redirect_target;
   logic       inst_ready;

   logic [7:0] rom_address;
   logic [8:0] rom_instruction;
   logic       inst_valid;
   logic [8:0] inst_data;
   logic [7:0] inst_pc;
   logic       busy;

   logic       start_fe;
   logic [7:0] rom_address_fe;
   logic [8:0] rom_instruction_fe;
   logic       inst_valid_fe;
   logic [8:0] inst_data_fe;
   logic [7:0] inst_pc_fe;
   logic       busy_fe;

   int n_checks = 0;
   int n_fails  = 0;

   always #5 clock = ~clock;

   instruction_fetch_unit dut (
      .clock           (clock),
      .reset           (reset),
      .start           (start),
      .halt            (halt),
      .rom_address     (rom_address),
      .rom_instruction (rom_instruction),
      .redirect_valid  (redirect_valid),
      .redirect_target (redirect_target),
      .inst_valid      (inst_valid),
      .inst_ready      (inst_ready),
      .inst_data       (inst_data),
      .inst_pc         (inst_pc),
      .busy            (busy)
   );

   instruction_fetch_unit #(.BOOT_ADDR(8'hFE)) dut_fe (
      .clock           (clock),
      .reset           (reset),
      .start           (start_fe),
      .halt            (1'b0),
      .rom_address     (rom_address_fe),
      .rom_instruction (rom_instruction_fe),
      .redirect_valid  (1'b0),
      .redirect_target (8'h00),
      .inst_valid      (inst_valid_fe),
      .inst_ready      (inst_ready),
      .inst_data       (inst_data_fe),
      .inst_pc         (inst_pc_fe),
      .busy            (busy_fe)
   );

   // Synchronous ROMs: address sampled at the edge, data valid the next cycle.
   always @(posedge clock) begin
      rom_instruction    <= 9'h100 + {1'b0, rom_address};
      rom_instruction_fe <= 9'h100 + {1'b0, rom_address_fe};
   end

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] observed,
                        input logic [31:0] expected);
      n_checks++;
      assert (observed === expected) else begin
         n_fails++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset           = 1'b1;
      start           = 1'b0;
      start_fe        = 1'b0;
      halt            = 1'b0;
      redirect_valid  = 1'b0;
      redirect_target = 8'h00;
      inst_ready      = 1'b0;

      // ---------------- reset state ----------------
      step();
      step();
      reset = 1'b0;
      check("reset_valid",      32'(inst_valid),     32'h0);
      check("reset_data",       32'(inst_data),      32'h0);
      check("reset_pc",         32'(inst_pc),        32'h0);
      check("reset_rom_addr",   32'(rom_address),    32'h0);
      check("reset_busy",       32'(busy),           32'h0);
      check("reset_rom_addr_fe",32'(rom_address_fe), 32'hFE);

      // ---------------- redirect in IDLE reloads PC only ----------------
      redirect_valid  = 1'b1;
      redirect_target = 8'h20;
      step();
      redirect_valid  = 1'b0;
      check("idle_redir_addr",  32'(rom_address), 32'h20);
      check("idle_redir_busy",  32'(busy),        32'h0);
      check("idle_redir_valid", 32'(inst_valid),  32'h0);
      step();
      check("idle_no_issue",    32'(rom_address), 32'h20);
      reset = 1'b1;
      step();
      reset = 1'b0;
      check("reset2_rom_addr",  32'(rom_address), 32'h0);

      // ---------------- start, streaming with ready high ----------------
      inst_ready = 1'b1;
      start      = 1'b1;
      step();                                   // cycle 1
      start      = 1'b0;
      check("c1_valid",    32'(inst_valid),  32'h0);
      check("c1_busy",     32'(busy),        32'h1);
      check("c1_rom_addr", 32'(rom_address), 32'h0);
      step();                                   // cycle 2
      check("c2_valid",    32'(inst_valid),  32'h0);
      check("c2_rom_addr", 32'(rom_address), 32'h1);
      step();                                   // cycle 3
      check("c3_valid",    32'(inst_valid),  32'h1);
      check("c3_pc",       32'(inst_pc),     32'h0);
      check("c3_data",     32'(inst_data),   32'h100);
      for (int i = 1; i <= 4; i++) begin
         step();
         check("stream_valid", 32'(inst_valid), 32'h1);
         check("stream_pc",    32'(inst_pc),    32'(i));
         check("stream_data",  32'(inst_data),  32'h100 + 32'(i));
      end

      // ---------------- reset mid-stream ----------------
      reset = 1'b1;
      step();
      reset = 1'b0;
      check("midreset_valid",    32'(inst_valid),  32'h0);
      check("midreset_rom_addr", 32'(rom_address), 32'h0);
      check("midreset_busy",     32'(busy),        32'h0);
      step();
      step();
      check("midreset_no_issue", 32'(rom_address), 32'h0);
      check("midreset_idle",     32'(inst_valid),  32'h0);

      // ---------------- backpressure: queue fills to 3 ----------------
      inst_ready = 1'b0;
      start      = 1'b1;
      step();                                   // cycle 1
      start      = 1'b0;
      step();                                   // cycle 2
      step();                                   // cycle 3
      check("bp_first_valid", 32'(inst_valid), 32'h1);
      check("bp_first_pc",    32'(inst_pc),    32'h0);
      for (int i = 0; i < 10; i++) begin
         step();
         check("bp_hold_valid",    32'(inst_valid),  32'h1);
         check("bp_hold_pc",       32'(inst_pc),     32'h0);
         check("bp_hold_data",     32'(inst_data),   32'h100);
         check("bp_hold_rom_addr", 32'(rom_address), 32'h3);
      end
      inst_ready = 1'b1;
      for (int i = 1; i <= 6; i++) begin
         step();
         check("bp_release_valid", 32'(inst_valid), 32'h1);
         check("bp_release_pc",    32'(inst_pc),    32'(i));
         check("bp_release_data",  32'(inst_data),  32'h100 + 32'(i));
      end

      // ---------------- redirect with 2 queued + 1 in flight ----------------
      inst_ready = 1'b0;
      step();
      check("pre_redir_pc",    32'(inst_pc),     32'h6);
      check("pre_redir_addr",  32'(rom_address), 32'h9);
      redirect_valid  = 1'b1;
      redirect_target = 8'h40;
      step();                                   // cycle r+1
      redirect_valid  = 1'b0;
      inst_ready      = 1'b1;
      check("redir_r1_valid",  32'(inst_valid),  32'h0);
      check("redir_r1_addr",   32'(rom_address), 32'h40);
      step();                                   // cycle r+2
      check("redir_r2_valid",  32'(inst_valid),  32'h0);
      step();                                   // cycle r+3
      check("redir_r3_valid",  32'(inst_valid),  32'h1);
      check("redir_r3_pc",     32'(inst_pc),     32'h40);
      check("redir_r3_data",   32'(inst_data),   32'h140);
      step();
      check("redir_r4_pc",     32'(inst_pc),     32'h41);
      check("redir_r4_data",   32'(inst_data),   32'h141);

      // ---------------- halt mid-stream ----------------
      halt = 1'b1;
      check("halt_cycle_addr", 32'(rom_address), 32'h43);
      step();
      halt = 1'b0;
      check("halt_h1_valid",   32'(inst_valid),  32'h1);
      check("halt_h1_pc",      32'(inst_pc),     32'h42);
      check("halt_h1_busy",    32'(busy),        32'h1);
      check("halt_h1_addr",    32'(rom_address), 32'h44);
      step();
      check("halt_h2_valid",   32'(inst_valid),  32'h1);
      check("halt_h2_pc",      32'(inst_pc),     32'h43);
      check("halt_h2_data",    32'(inst_data),   32'h143);
      check("halt_h2_busy",    32'(busy),        32'h0);
      step();
      check("halt_h3_valid",   32'(inst_valid),  32'h0);
      check("halt_h3_addr",    32'(rom_address), 32'h44);
      step();
      check("halt_h4_addr",    32'(rom_address), 32'h44);
      check("halt_h4_busy",    32'(busy),        32'h0);
      start = 1'b1;
      step();
      start = 1'b0;
      check("resume_busy",     32'(busy),        32'h1);
      check("resume_valid",    32'(inst_valid),  32'h0);
      step();
      step();
      check("resume_valid3",   32'(inst_valid),  32'h1);
      check("resume_pc",       32'(inst_pc),     32'h44);
      check("resume_data",     32'(inst_data),   32'h144);

      // ---------------- BOOT_ADDR = 0xFE, PC wrap ----------------
      start_fe = 1'b1;
      step();
      start_fe = 1'b0;
      check("fe_c1_valid",     32'(inst_valid_fe), 32'h0);
      check("fe_c1_busy",      32'(busy_fe),       32'h1);
      step();
      step();
      check("fe_valid0",       32'(inst_valid_fe), 32'h1);
      check("fe_pc0",          32'(inst_pc_fe),    32'hFE);
      check("fe_data0",        32'(inst_data_fe),  32'h1FE);
      step();
      check("fe_pc1",          32'(inst_pc_fe),    32'hFF);
      check("fe_data1",        32'(inst_data_fe),  32'h1FF);
      step();
      check("fe_pc2",          32'(inst_pc_fe),    32'h00);
      check("fe_data2",        32'(inst_data_fe),  32'h100);
      step();
      check("fe_pc3",          32'(inst_pc_fe),    32'h01);
      check("fe_data3",        32'(inst_data_fe),  32'h101);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
